// File: rtl/softcore_pkg.sv
// Shared softcore types: register address width, data width and the
// write-back entry carried from producers to the register file.
package softcore_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef struct packed {
      reg_addr_t        rd;
      logic [XLEN-1:0]  data;
   } wb_entry_t;

   function automatic logic [31:0] reg_onehot(input reg_addr_t r);
      reg_onehot = 32'd1 << r;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for long-latency write-back results; exposes a per-entry
// valid/rd view so the arbiter can build its pending-write mask.
module wb_fifo
   import softcore_pkg::REG_ADDR_W;
#(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              push,
   input  logic [REG_ADDR_W-1:0]             push_rd,
   input  logic [DATA_W-1:0]                 push_data,
   input  logic                              pop,
   output logic                              full,
   output logic                              empty,
   output logic [REG_ADDR_W-1:0]             head_rd,
   output logic [DATA_W-1:0]                 head_data,
   output logic [DEPTH-1:0]                  entry_valid,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]  entry_rd
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0]                 wr_ptr;
   logic [PTR_W-1:0]                 rd_ptr;
   logic [PTR_W:0]                   count;
   logic [DEPTH-1:0]                 valid;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_mem;
   logic [DATA_W-1:0]                data_mem [DEPTH];
   logic                             do_push;
   logic                             do_pop;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // NOTE: storage arrays carry no reset; the reset valid bits are what make
   // a slot meaningful, so stale contents after reset are never observed.
   always_ff @(posedge clk) begin
      if (do_push) begin
         rd_mem[wr_ptr]   <= push_rd;
         data_mem[wr_ptr] <= push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         valid  <= '0;
      end else begin
         if (do_pop) begin
            valid[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + 1'b1;
         end
         if (do_push) begin
            valid[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_rd     = rd_mem[rd_ptr];
   assign head_data   = data_mem[rd_ptr];
   assign entry_valid = valid;
   assign entry_rd    = rd_mem;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and long-latency write-back streams onto the single register
// file write port, with FIFO buffering, starvation protection and busy mask.
module writeback_arbiter
   import softcore_pkg::REG_ADDR_W;
   import softcore_pkg::reg_onehot;
#(
   parameter int XLEN         = 32,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_valid,
   input  logic [REG_ADDR_W-1:0] a_rd,
   input  logic [XLEN-1:0]       a_data,
   output logic                  a_ready,
   input  logic                  l_valid,
   input  logic [REG_ADDR_W-1:0] l_rd,
   input  logic [XLEN-1:0]       l_data,
   output logic                  l_ready,
   output logic                  we,
   output logic [REG_ADDR_W-1:0] rd_addr,
   output logic [XLEN-1:0]       rd_data,
   output logic [31:0]           busy_mask
);

   localparam logic [3:0] AGE_MAX   = 4'hF;
   localparam logic [3:0] AGE_LIMIT = 4'(STARVE_LIMIT);

   logic                             fifo_full;
   logic                             fifo_empty;
   logic [REG_ADDR_W-1:0]            head_rd;
   logic [XLEN-1:0]                  head_data;
   logic [DEPTH-1:0]                 entry_valid;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;
   logic                             l_push;
   logic                             fifo_grant;
   logic                             a_xfer;
   logic [3:0]                       age;
   logic [31:0]                      busy;

   assign l_ready = ~fifo_full;
   assign l_push  = l_valid & l_ready;

   wb_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (XLEN)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (l_push),
      .push_rd     (l_rd),
      .push_data   (l_data),
      .pop         (fifo_grant),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .head_rd     (head_rd),
      .head_data   (head_data),
      .entry_valid (entry_valid),
      .entry_rd    (entry_rd)
   );

   // FIFO wins when the ALU is idle, when it is full, or when its head has starved.
   assign fifo_grant = ~fifo_empty & (~a_valid | fifo_full | (age >= AGE_LIMIT));
   assign a_ready    = ~fifo_grant;
   assign a_xfer     = a_valid & a_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         age <= '0;
      end else if (fifo_empty || fifo_grant) begin
         age <= '0;
      end else if (age != AGE_MAX) begin
         age <= age + 1'b1;
      end
   end

   // x0 results are consumed like any other, but never raise the write enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we      <= 1'b0;
         rd_addr <= '0;
         rd_data <= '0;
      end else if (fifo_grant) begin
         we      <= (head_rd != '0);
         rd_addr <= head_rd;
         rd_data <= head_data;
      end else if (a_xfer) begin
         we      <= (a_rd != '0);
         rd_addr <= a_rd;
         rd_data <= a_data;
      end else begin
         we      <= 1'b0;
      end
   end

   // NOTE: every combinational variable gets a default before any conditional
   // update, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      busy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i]) busy = busy | reg_onehot(entry_rd[i]);
      end
      if (we) busy = busy | reg_onehot(rd_addr);
      busy[0] = 1'b0;
   end

   assign busy_mask = busy;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_writeback_arbiter;
   import softcore_pkg::*;

   localparam int DEPTH        = 4;
   localparam int STARVE_LIMIT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_valid;
   logic [4:0]  a_rd;
   logic [31:0] a_data;
   logic        a_ready;
   logic        l_valid;
   logic [4:0]  l_rd;
   logic [31:0] l_data;
   logic        l_ready;
   logic        we;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic [31:0] busy_mask;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   wb_entry_t   mq[$];
   logic        m_we;
   logic [4:0]  m_rd_addr;
   logic [31:0] m_rd_data;
   int          m_age;

   // Register file that the block feeds
   logic [31:0] rf [32];

   always #5 clk = ~clk;

   writeback_arbiter #(
      .XLEN         (32),
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid   (a_valid),
      .a_rd      (a_rd),
      .a_data    (a_data),
      .a_ready   (a_ready),
      .l_valid   (l_valid),
      .l_rd      (l_rd),
      .l_data    (l_data),
      .l_ready   (l_ready),
      .we        (we),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .busy_mask (busy_mask)
   );

   always @(posedge clk) begin
      if (rst_n && we) rf[rd_addr] <= rd_data;
   end

   function automatic bit m_grant();
      return (mq.size() != 0) &&
             (!a_valid || mq.size() == DEPTH || m_age >= STARVE_LIMIT);
   endfunction

   function automatic logic [31:0] m_busy();
      logic [31:0] b;
      b = '0;
      foreach (mq[i]) b[mq[i].rd] = 1'b1;
      if (m_we) b[m_rd_addr] = 1'b1;
      b[0] = 1'b0;
      return b;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_we      = 1'b0;
      m_rd_addr = '0;
      m_rd_data = '0;
      m_age     = 0;
   endtask

   // Advance the model by one clock using the current inputs, then move to the next falling edge.
   task automatic tick(output bit a_acc, output bit l_acc);
      bit        g;
      bit        nonempty;
      wb_entry_t e;
      g        = m_grant();
      nonempty = (mq.size() != 0);
      a_acc    = a_valid && !g;
      l_acc    = l_valid && (mq.size() < DEPTH);
      if (g) begin
         e         = mq.pop_front();
         m_we      = (e.rd != 0);
         m_rd_addr = e.rd;
         m_rd_data = e.data;
      end else if (a_acc) begin
         m_we      = (a_rd != 0);
         m_rd_addr = a_rd;
         m_rd_data = a_data;
      end else begin
         m_we = 1'b0;
      end
      if (!nonempty || g) m_age = 0;
      else if (m_age < 15) m_age++;
      if (l_acc) begin
         e.rd   = l_rd;
         e.data = l_data;
         mq.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      a_valid = 1'b0; a_rd = '0; a_data = '0;
      l_valid = 1'b0; l_rd = '0; l_data = '0;
   endtask

   task automatic test_reset();
      bit aa, la;
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b exp 0", we); end
      n_checks++; if (rd_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d exp 0", rd_addr); end
      n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h exp 0", rd_data); end
      n_checks++; if (l_ready !== 1'b1) begin n_fail++; $display("FAIL reset_l_ready: got %b exp 1", l_ready); end
      n_checks++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h exp 0", busy_mask); end
      rst_n = 1'b1;
      model_reset();
      tick(aa, la);
   endtask

   task automatic test_alu_alone();
      bit aa, la;
      a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h12345678;
      #1;
      n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL alu_a_ready: got %b exp 1", a_ready); end
      tick(aa, la);
      a_valid = 1'b0;
      #1;
      n_checks++; if (we !== 1'b1) begin n_fail++; $display("FAIL alu_we: got %b exp 1", we); end
      n_checks++; if (rd_addr !== 5'd3) begin n_fail++; $display("FAIL alu_rd_addr: got %0d exp 3", rd_addr); end
      n_checks++; if (rd_data !== 32'h12345678) begin n_fail++; $display("FAIL alu_rd_data: got %h exp 12345678", rd_data); end
      n_checks++; if (busy_mask !== 32'h8) begin n_fail++; $display("FAIL alu_busy: got %h exp 00000008", busy_mask); end
      tick(aa, la);
      #1;
      n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL alu_we_after: got %b exp 0", we); end
      n_checks++; if (rf[3] !== 32'h12345678) begin n_fail++; $display("FAIL alu_rf_read: got %h exp 12345678", rf[3]); end
   endtask

   task automatic test_l_alone();
      bit aa, la;
      l_valid = 1'b1; l_rd = 5'd7; l_data = 32'hCAFEF00D;
      #1;
      n_checks++; if (l_ready !== 1'b1) begin n_fail++; $display("FAIL l_ready: got %b exp 1", l_ready); end
      tick(aa, la);
      l_valid = 1'b0;
      #1;
      n_checks++; if (busy_mask !== 32'h80) begin n_fail++; $display("FAIL l_busy_n1: got %h exp 00000080", busy_mask); end
      n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL l_we_n1: got %b exp 0", we); end
      n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL l_a_ready_grant: got %b exp 0", a_ready); end
      tick(aa, la);
      #1;
      n_checks++; if (we !== 1'b1 || rd_addr !== 5'd7) begin n_fail++; $display("FAIL l_write_n2: got we=%b rd=%0d exp we=1 rd=7", we, rd_addr); end
      n_checks++; if (rd_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL l_data_n2: got %h exp cafef00d", rd_data); end
      n_checks++; if (busy_mask !== 32'h80) begin n_fail++; $display("FAIL l_busy_n2: got %h exp 00000080", busy_mask); end
      tick(aa, la);
      #1;
      n_checks++; if (busy_mask !== 32'd0 || we !== 1'b0) begin n_fail++; $display("FAIL l_done: got busy=%h we=%b exp busy=0 we=0", busy_mask, we); end
   endtask

   task automatic test_x0();
      bit aa, la;
      a_valid = 1'b1; a_rd = 5'd0; a_data = 32'hDEADBEEF;
      #1;
      n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL x0_a_ready: got %b exp 1", a_ready); end
      tick(aa, la);
      a_valid = 1'b0;
      #1;
      n_checks++; if (we !== 1'b0 || busy_mask[0] !== 1'b0) begin n_fail++; $display("FAIL x0_alu: got we=%b busy0=%b exp 0 0", we, busy_mask[0]); end
      l_valid = 1'b1; l_rd = 5'd0; l_data = 32'h0BADF00D;
      tick(aa, la);
      l_valid = 1'b0;
      #1;
      n_checks++; if (busy_mask !== 32'd0) begin n_fail++; $display("FAIL x0_l_busy: got %h exp 0", busy_mask); end
      n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL x0_l_pop: got a_ready=%b exp 0", a_ready); end
      tick(aa, la);
      #1;
      n_checks++; if (we !== 1'b0 || busy_mask !== 32'd0) begin n_fail++; $display("FAIL x0_l_write: got we=%b busy=%h exp 0 0", we, busy_mask); end
      n_checks++; if (l_ready !== 1'b1 || a_ready !== 1'b1) begin n_fail++; $display("FAIL x0_drained: got l_ready=%b a_ready=%b exp 1 1", l_ready, a_ready); end
   endtask

   task automatic test_fill_starve();
      bit aa, la;
      int pushed;
      bit saw_full;
      int l_cycles[$];
      logic [4:0] l_order[$];
      pushed   = 0;
      saw_full = 1'b0;
      a_valid = 1'b1; a_rd = 5'(16 + $urandom_range(0, 15)); a_data = $urandom;
      for (int cyc = 0; cyc < 30; cyc++) begin
         l_valid = (pushed < 4);
         l_rd    = 5'(8 + pushed);
         l_data  = 32'hA000_0000 | 32'(pushed);
         #1;
         if (l_ready === 1'b0) saw_full = 1'b1;
         if (we === 1'b1 && rd_addr >= 5'd8 && rd_addr <= 5'd11) begin
            l_cycles.push_back(cyc);
            l_order.push_back(rd_addr);
         end
         n_checks++; if (we !== m_we || rd_addr !== m_rd_addr) begin n_fail++; $display("FAIL fill_out c%0d: got we=%b rd=%0d exp we=%b rd=%0d", cyc, we, rd_addr, m_we, m_rd_addr); end
         tick(aa, la);
         if (la) pushed++;
         if (aa) begin a_rd = 5'(16 + $urandom_range(0, 15)); a_data = $urandom; end
      end
      idle_inputs();
      n_checks++; if (!saw_full) begin n_fail++; $display("FAIL fill_l_ready_low: got never-full exp l_ready=0 when full"); end
      n_checks++; if (l_order.size() != 4) begin n_fail++; $display("FAIL fill_count: got %0d writes exp 4", l_order.size()); end
      foreach (l_order[i]) begin
         n_checks++; if (l_order[i] !== 5'(8 + i)) begin n_fail++; $display("FAIL fill_order[%0d]: got %0d exp %0d", i, l_order[i], 8 + i); end
         if (i > 0) begin
            n_checks++; if (l_cycles[i] - l_cycles[i-1] > STARVE_LIMIT + 1) begin n_fail++; $display("FAIL fill_starve[%0d]: got gap %0d exp <= %0d", i, l_cycles[i] - l_cycles[i-1], STARVE_LIMIT + 1); end
         end
      end
      repeat (2) tick(aa, la);
   endtask

   task automatic test_push_pop();
      bit aa, la;
      a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h1;
      l_valid = 1'b1; l_rd = 5'd12; l_data = 32'hC12;
      tick(aa, la);
      a_rd = 5'd2; a_data = 32'h2;
      l_rd = 5'd13; l_data = 32'hC13;
      #1;
      n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL pp_alu_wins: got a_ready=%b exp 1", a_ready); end
      tick(aa, la);
      a_valid = 1'b0;
      l_rd = 5'd14; l_data = 32'hC14;
      #1;
      n_checks++; if (a_ready !== 1'b0 || l_ready !== 1'b1) begin n_fail++; $display("FAIL pp_both: got a_ready=%b l_ready=%b exp 0 1", a_ready, l_ready); end
      tick(aa, la);
      l_valid = 1'b0;
      #1;
      n_checks++; if (busy_mask !== 32'h0000_7000) begin n_fail++; $display("FAIL pp_occupancy: got busy=%h exp 00007000", busy_mask); end
      n_checks++; if (we !== 1'b1 || rd_addr !== 5'd12 || rd_data !== 32'hC12) begin n_fail++; $display("FAIL pp_w12: got we=%b rd=%0d d=%h exp 1 12 c12", we, rd_addr, rd_data); end
      tick(aa, la);
      #1;
      n_checks++; if (rd_addr !== 5'd13 || rd_data !== 32'hC13) begin n_fail++; $display("FAIL pp_w13: got rd=%0d d=%h exp 13 c13", rd_addr, rd_data); end
      tick(aa, la);
      #1;
      n_checks++; if (rd_addr !== 5'd14 || rd_data !== 32'hC14) begin n_fail++; $display("FAIL pp_w14: got rd=%0d d=%h exp 14 c14", rd_addr, rd_data); end
      tick(aa, la);
      #1;
      n_checks++; if (we !== 1'b0 || busy_mask !== 32'd0) begin n_fail++; $display("FAIL pp_drained: got we=%b busy=%h exp 0 0", we, busy_mask); end
   endtask

   task automatic test_reset_mid_drain();
      bit aa, la;
      a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h11;
      for (int i = 0; i < 3; i++) begin
         l_valid = 1'b1; l_rd = 5'(20 + i); l_data = 32'hB0 + 32'(i);
         tick(aa, la);
      end
      idle_inputs();
      #1;
      n_checks++; if (busy_mask !== 32'h0070_0002) begin n_fail++; $display("FAIL rst_pre_busy: got %h exp 00700002", busy_mask); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (we !== 1'b0 || busy_mask !== 32'd0) begin n_fail++; $display("FAIL rst_mid: got we=%b busy=%h exp 0 0", we, busy_mask); end
      n_checks++; if (l_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_l_ready: got %b exp 1", l_ready); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_checks++; if (we !== 1'b0 || busy_mask !== 32'd0) begin n_fail++; $display("FAIL rst_stale c%0d: got we=%b busy=%h exp 0 0", i, we, busy_mask); end
         tick(aa, la);
      end
   endtask

   task automatic test_random();
      bit aa, la;
      aa = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!a_valid || aa) begin
            a_valid = ($urandom_range(0, 9) < 7);
            a_rd    = 5'($urandom_range(0, 31));
            a_data  = $urandom;
         end
         l_valid = ($urandom_range(0, 9) < 6);
         l_rd    = 5'($urandom_range(0, 31));
         l_data  = $urandom;
         #1;
         n_checks++; if (a_ready !== !m_grant()) begin n_fail++; $display("FAIL rnd_a_ready c%0d: got %b exp %b", cyc, a_ready, !m_grant()); end
         n_checks++; if (l_ready !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_l_ready c%0d: got %b exp %b", cyc, l_ready, mq.size() < DEPTH); end
         n_checks++; if (we !== m_we) begin n_fail++; $display("FAIL rnd_we c%0d: got %b exp %b", cyc, we, m_we); end
         n_checks++; if (rd_addr !== m_rd_addr) begin n_fail++; $display("FAIL rnd_rd_addr c%0d: got %0d exp %0d", cyc, rd_addr, m_rd_addr); end
         n_checks++; if (rd_data !== m_rd_data) begin n_fail++; $display("FAIL rnd_rd_data c%0d: got %h exp %h", cyc, rd_data, m_rd_data); end
         n_checks++; if (busy_mask !== m_busy()) begin n_fail++; $display("FAIL rnd_busy c%0d: got %h exp %h", cyc, busy_mask, m_busy()); end
         tick(aa, la);
      end
      idle_inputs();
   endtask

   initial begin
      foreach (rf[i]) rf[i] = '0;
      model_reset();
      test_reset();
      test_alu_alone();
      test_l_alone();
      test_x0();
      test_fill_starve();
      test_push_pop();
      test_reset_mid_drain();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
